nexys2_flash_cmd_sequencer: RTL and testbench

Command sequencer in front of the Nexys2 flash controller's port 1. It turns one-shot host operations (read, word program, block erase, block unlock, read/clear status) into the multi-cycle StrataFlash bus-cycle sequences, including status polling. It drives the controller's request and write-enable inputs through the edge-triggered req/ready handshake and returns data, status and an error indication to the host.

---
 rtl/nexys2_flash_cmd_sequencer.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_nexys2_flash_cmd_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nexys2_flash_cmd_sequencer.sv
// nexys2_flash_cmd_sequencer
//
// Turns one-shot host operations into StrataFlash bus-cycle sequences on
// port 1 of the Nexys2 flash controller, including status-register polling.
//
// Handshake with the controller: a rising edge on o_p1_req starts one access.
// Address, write data and write enable are held stable while o_p1_req is high.
// The controller answers with a one-cycle i_p1_ready pulse, which is accepted
// only in S_WAIT. o_p1_req then drops and stays low for at least GAP_CYCLES.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_cmd_start         start pulse, sampled only while idle
//   i_cmd_op            0 READ, 1 PROGRAM, 2 ERASE, 3 UNLOCK,
//                       4 READ_STATUS, 5 CLEAR_STATUS, 6/7 illegal
//   i_cmd_addr          word address, latched at accept
//   i_cmd_wdata         program data, latched at accept
//   o_cmd_busy          operation in progress
//   o_cmd_done          one-cycle completion pulse
//   o_cmd_error         SR error bit, poll timeout or illegal op
//   o_cmd_timeout       poll limit reached
//   o_cmd_status        last captured status register value
//   o_cmd_rdata         READ result
//   o_p1_address, o_p1_to_mem, o_p1_wren, o_p1_req   to the controller
//   i_p1_from_mem, i_p1_ready                        from the controller
module nexys2_flash_cmd_sequencer #(
    parameter logic [23:0] POLL_LIMIT = 24'd2000000,
    parameter int          GAP_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_start,
    input  logic [2:0]  i_cmd_op,
    input  logic [22:0] i_cmd_addr,
    input  logic [15:0] i_cmd_wdata,
    output logic        o_cmd_busy,
    output logic        o_cmd_done,
    output logic        o_cmd_error,
    output logic        o_cmd_timeout,
    output logic [7:0]  o_cmd_status,
    output logic [15:0] o_cmd_rdata,
    output logic [22:0] o_p1_address,
    output logic [15:0] o_p1_to_mem,
    output logic        o_p1_wren,
    output logic        o_p1_req,
    input  logic [15:0] i_p1_from_mem,
    input  logic        i_p1_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_POLL_CHECK,
        S_FINISH
    } state_t;

    localparam logic [2:0] OP_READ         = 3'd0;
    localparam logic [2:0] OP_PROGRAM      = 3'd1;
    localparam logic [2:0] OP_ERASE        = 3'd2;
    localparam logic [2:0] OP_UNLOCK       = 3'd3;
    localparam logic [2:0] OP_READ_STATUS  = 3'd4;
    localparam logic [2:0] OP_CLEAR_STATUS = 3'd5;

    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;

    logic [2:0]  r_op;
    logic [22:0] r_addr;
    logic [15:0] r_wdata;
    logic [1:0]  r_step;
    logic        r_array_mode;
    logic [23:0] r_poll_cnt;
    logic [7:0]  r_poll_data;
    logic [15:0] r_gap_cnt;

    logic        r_cmd_error;
    logic        r_cmd_timeout;
    logic [7:0]  r_cmd_status;
    logic [15:0] r_cmd_rdata;
    logic [22:0] r_p1_address;
    logic [15:0] r_p1_to_mem;
    logic        r_p1_wren;
    logic        r_p1_req;

    // Current step of the latched operation: a write of w_step_data, or a read.
    // Poll steps repeat in place, so they are never the last step; the
    // status check decides when the poll loop ends.
    logic        w_step_wr;
    logic [15:0] w_step_data;
    logic        w_step_poll;
    logic        w_step_last;

    logic        w_op_legal;
    logic        w_gap_done;
    logic        w_sr_ready;
    logic        w_poll_exhausted;

    assign w_op_legal       = (i_cmd_op <= OP_CLEAR_STATUS);
    assign w_gap_done       = (r_gap_cnt == GAP_LAST);
    assign w_sr_ready       = r_poll_data[7];
    assign w_poll_exhausted = (r_poll_cnt == POLL_LIMIT);

    always_comb begin
        w_step_wr   = 1'b0;
        w_step_data = 16'h0000;
        w_step_poll = 1'b0;
        w_step_last = 1'b0;
        case (r_op)
            OP_READ: begin
                if (r_step == 2'd0) begin
                    w_step_wr   = 1'b1;
                    w_step_data = 16'h00FF;
                end else begin
                    w_step_last = 1'b1;
                end
            end
            OP_PROGRAM, OP_ERASE, OP_UNLOCK: begin
                if (r_step == 2'd0) begin
                    w_step_wr   = 1'b1;
                    w_step_data = (r_op == OP_PROGRAM) ? 16'h0040 :
                                  (r_op == OP_ERASE)   ? 16'h0020 : 16'h0060;
                end else if (r_step == 2'd1) begin
                    w_step_wr   = 1'b1;
                    w_step_data = (r_op == OP_PROGRAM) ? r_wdata : 16'h00D0;
                end else begin
                    w_step_poll = 1'b1;
                end
            end
            OP_READ_STATUS: begin
                if (r_step == 2'd0) begin
                    w_step_wr   = 1'b1;
                    w_step_data = 16'h0070;
                end else begin
                    w_step_last = 1'b1;
                end
            end
            OP_CLEAR_STATUS: begin
                w_step_wr   = 1'b1;
                w_step_data = 16'h0050;
                w_step_last = 1'b1;
            end
            default: begin
                w_step_last = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_start) begin
                    w_next_state = w_op_legal ? S_ISSUE : S_FINISH;
                end
            end
            S_ISSUE: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (i_p1_ready) begin
                    w_next_state = w_step_poll ? S_POLL_CHECK : S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_done) begin
                    w_next_state = w_step_last ? S_FINISH : S_ISSUE;
                end
            end
            S_POLL_CHECK: begin
                // SR7 is checked before the poll limit so a ready status on
                // the final allowed read still counts as success.
                if (w_sr_ready || w_poll_exhausted) begin
                    w_next_state = S_FINISH;
                end else begin
                    w_next_state = S_GAP;
                end
            end
            S_FINISH: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op          <= 3'd0;
            r_addr        <= 23'd0;
            r_wdata       <= 16'd0;
            r_step        <= 2'd0;
            r_array_mode  <= 1'b0;
            r_poll_cnt    <= 24'd0;
            r_poll_data   <= 8'd0;
            r_gap_cnt     <= 16'd0;
            r_cmd_error   <= 1'b0;
            r_cmd_timeout <= 1'b0;
            r_cmd_status  <= 8'd0;
            r_cmd_rdata   <= 16'd0;
            r_p1_address  <= 23'd0;
            r_p1_to_mem   <= 16'd0;
            r_p1_wren     <= 1'b0;
            r_p1_req      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_start) begin
                        r_op          <= i_cmd_op;
                        r_addr        <= i_cmd_addr;
                        r_wdata       <= i_cmd_wdata;
                        r_cmd_error   <= ~w_op_legal;
                        r_cmd_timeout <= 1'b0;
                        r_poll_cnt    <= 24'd0;
                        // Device already in read-array mode: skip the 00FF write.
                        r_step        <= (i_cmd_op == OP_READ && r_array_mode) ? 2'd1 : 2'd0;
                        r_array_mode  <= (i_cmd_op == OP_READ);
                    end
                end
                S_ISSUE: begin
                    r_p1_address <= r_addr;
                    r_p1_to_mem  <= w_step_data;
                    r_p1_wren    <= w_step_wr;
                    r_p1_req     <= 1'b1;
                end
                S_WAIT: begin
                    if (i_p1_ready) begin
                        r_p1_req  <= 1'b0;
                        r_gap_cnt <= 16'd0;
                        if (w_step_wr) begin
                            if (r_op == OP_CLEAR_STATUS) begin
                                r_cmd_status <= 8'd0;
                            end
                        end else if (w_step_poll) begin
                            r_poll_data <= i_p1_from_mem[7:0];
                            r_poll_cnt  <= r_poll_cnt + 24'd1;
                        end else if (r_op == OP_READ) begin
                            r_cmd_rdata <= i_p1_from_mem;
                        end else begin
                            r_cmd_status <= i_p1_from_mem[7:0];
                        end
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt + 16'd1;
                    if (w_gap_done && !w_step_last && !w_step_poll) begin
                        r_step <= r_step + 2'd1;
                    end
                end
                S_POLL_CHECK: begin
                    r_gap_cnt <= 16'd0;
                    if (w_sr_ready) begin
                        r_cmd_status <= r_poll_data;
                        r_cmd_error  <= r_poll_data[5] | r_poll_data[4] |
                                        r_poll_data[3] | r_poll_data[1];
                    end else if (w_poll_exhausted) begin
                        r_cmd_status  <= r_poll_data;
                        r_cmd_timeout <= 1'b1;
                        r_cmd_error   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_cmd_busy    = (r_state != S_IDLE);
    assign o_cmd_done    = (r_state == S_FINISH);
    assign o_cmd_error   = r_cmd_error;
    assign o_cmd_timeout = r_cmd_timeout;
    assign o_cmd_status  = r_cmd_status;
    assign o_cmd_rdata   = r_cmd_rdata;
    assign o_p1_address  = r_p1_address;
    assign o_p1_to_mem   = r_p1_to_mem;
    assign o_p1_wren     = r_p1_wren;
    assign o_p1_req      = r_p1_req;

endmodule

// File: tb/tb_nexys2_flash_cmd_sequencer.sv
// Directed bench for nexys2_flash_cmd_sequencer. A behavioural controller
// model answers each o_p1_req rising edge after a fixed latency. Every bus
// access the DUT starts is checked against the expected-access queue.
module tb_nexys2_flash_cmd_sequencer;

    localparam logic [23:0] POLL_LIMIT = 24'd4;
    localparam int          GAP_CYCLES = 2;
    localparam int          MEM_LAT    = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_start;
    logic [2:0]  cmd_op;
    logic [22:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        cmd_busy;
    logic        cmd_done;
    logic        cmd_error;
    logic        cmd_timeout;
    logic [7:0]  cmd_status;
    logic [15:0] cmd_rdata;
    logic [22:0] p1_address;
    logic [15:0] p1_to_mem;
    logic        p1_wren;
    logic        p1_req;
    logic [15:0] p1_from_mem = 16'h0000;
    logic        p1_ready = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    // Expected accesses: {wren, address, write data (0 for reads)}.
    logic [39:0] exp_q[$];
    // Data returned by the controller model for reads; 0000 once empty.
    logic [15:0] rd_q[$];

    nexys2_flash_cmd_sequencer #(
        .POLL_LIMIT(POLL_LIMIT),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cmd_start  (cmd_start),
        .i_cmd_op     (cmd_op),
        .i_cmd_addr   (cmd_addr),
        .i_cmd_wdata  (cmd_wdata),
        .o_cmd_busy   (cmd_busy),
        .o_cmd_done   (cmd_done),
        .o_cmd_error  (cmd_error),
        .o_cmd_timeout(cmd_timeout),
        .o_cmd_status (cmd_status),
        .o_cmd_rdata  (cmd_rdata),
        .o_p1_address (p1_address),
        .o_p1_to_mem  (p1_to_mem),
        .o_p1_wren    (p1_wren),
        .o_p1_req     (p1_req),
        .i_p1_from_mem(p1_from_mem),
        .i_p1_ready   (p1_ready)
    );

    always #5 clk = ~clk;

    // Controller model; keeps finishing an in-flight access across a DUT reset.
    logic        m_busy     = 1'b0;
    logic        m_prev_req = 1'b0;
    logic        m_wr       = 1'b0;
    logic [15:0] m_rdata    = 16'h0000;
    int          m_lat      = 0;

    always @(negedge clk) begin
        logic [39:0] got;
        logic [39:0] want;
        logic        have;
        p1_ready = 1'b0;
        if (m_busy) begin
            m_lat = m_lat - 1;
            if (m_lat == 0) begin
                p1_ready    = 1'b1;
                p1_from_mem = m_wr ? 16'h0000 : m_rdata;
                m_busy      = 1'b0;
            end
        end else if (p1_req && !m_prev_req) begin
            got  = {p1_wren, p1_address, (p1_wren ? p1_to_mem : 16'h0000)};
            have = (exp_q.size() != 0);
            want = have ? exp_q.pop_front() : 40'h0;
            vectors++;
            assert (have && (got === want)) else begin
                miscompares++;
                $error("FAIL bus_access: got %h expected %h (queued=%0d)", got, want, have);
            end
            m_busy  = 1'b1;
            m_lat   = MEM_LAT;
            m_wr    = p1_wren;
            m_rdata = (!p1_wren && rd_q.size() != 0) ? rd_q.pop_front() : 16'h0000;
        end
        m_prev_req = p1_req;
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_w(input logic [22:0] addr, input logic [15:0] data);
        exp_q.push_back({1'b1, addr, data});
    endtask

    task automatic push_r(input logic [22:0] addr);
        exp_q.push_back({1'b0, addr, 16'h0000});
    endtask

    // Starts one operation, scrambles the command inputs after accept,
    // optionally pokes cmd_start while busy, and counts done pulses.
    task automatic do_cmd(input logic [2:0] op, input logic [22:0] addr,
                          input logic [15:0] wd, input bit poke, output int ndone);
        int cyc;
        ndone = 0;
        @(negedge clk);
        cmd_start = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        @(negedge clk);
        cmd_start = 1'b0;
        cmd_op    = 3'd2;
        cmd_addr  = 23'h7FFFFF;
        cmd_wdata = 16'hDEAD;
        cyc = 0;
        while (cmd_busy && cyc < 2000) begin
            if (cmd_done) ndone++;
            cmd_start = (poke && cyc == 3);
            @(negedge clk);
            cyc++;
        end
        cmd_start = 1'b0;
        check("busy_bound", {39'd0, (cyc < 2000)}, 40'd1);
        check("done_count", ndone, 1);
        check("access_queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    cmd_busy,    0);
        check({tag, "_done"},    cmd_done,    0);
        check({tag, "_error"},   cmd_error,   0);
        check({tag, "_timeout"}, cmd_timeout, 0);
        check({tag, "_status"},  cmd_status,  0);
        check({tag, "_rdata"},   cmd_rdata,   0);
        check({tag, "_p1_bus"},  {p1_req, p1_wren, p1_address, p1_to_mem}, 0);
    endtask

    initial begin
        int nd;
        int cyc;
        rst       = 1'b1;
        cmd_start = 1'b0;
        cmd_op    = 3'd0;
        cmd_addr  = 23'd0;
        cmd_wdata = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // READ from unknown mode: 00FF then read.
        push_w(23'h000100, 16'h00FF);
        push_r(23'h000100);
        rd_q.push_back(16'hBEEF);
        do_cmd(3'd0, 23'h000100, 16'h0000, 1'b0, nd);
        check("read1_rdata", cmd_rdata, 16'hBEEF);
        check("read1_error", cmd_error, 0);

        // Second READ: device already in array mode, read only.
        push_r(23'h000100);
        rd_q.push_back(16'h1357);
        do_cmd(3'd0, 23'h000100, 16'h0000, 1'b0, nd);
        check("read2_rdata", cmd_rdata, 16'h1357);

        // PROGRAM: SR ready on the 4th read, which is also the poll limit.
        push_w(23'h001000, 16'h0040);
        push_w(23'h001000, 16'h1234);
        repeat (4) push_r(23'h001000);
        rd_q.push_back(16'h0000);
        rd_q.push_back(16'h0000);
        rd_q.push_back(16'h0000);
        rd_q.push_back(16'h0080);
        do_cmd(3'd1, 23'h001000, 16'h1234, 1'b0, nd);
        check("prog_status",  cmd_status,  8'h80);
        check("prog_error",   cmd_error,   0);
        check("prog_timeout", cmd_timeout, 0);
        check("prog_rdata_held", cmd_rdata, 16'h1357);

        // ERASE: SR7 with erase-error bit 5.
        push_w(23'h002000, 16'h0020);
        push_w(23'h002000, 16'h00D0);
        push_r(23'h002000);
        rd_q.push_back(16'h00A0);
        do_cmd(3'd2, 23'h002000, 16'h0000, 1'b0, nd);
        check("erase_status",  cmd_status,  8'hA0);
        check("erase_error",   cmd_error,   1);
        check("erase_timeout", cmd_timeout, 0);

        // UNLOCK with SR stuck at 0000: exactly POLL_LIMIT polls then timeout.
        push_w(23'h003000, 16'h0060);
        push_w(23'h003000, 16'h00D0);
        repeat (4) push_r(23'h003000);
        do_cmd(3'd3, 23'h003000, 16'h0000, 1'b0, nd);
        check("unlock_timeout", cmd_timeout, 1);
        check("unlock_error",   cmd_error,   1);
        check("unlock_status",  cmd_status,  8'h00);

        // READ_STATUS: error and timeout cleared at accept.
        push_w(23'h000040, 16'h0070);
        push_r(23'h000040);
        rd_q.push_back(16'h5591);
        do_cmd(3'd4, 23'h000040, 16'h0000, 1'b0, nd);
        check("rs_status",  cmd_status,  8'h91);
        check("rs_error",   cmd_error,   0);
        check("rs_timeout", cmd_timeout, 0);

        // CLEAR_STATUS zeroes the captured status.
        push_w(23'h000050, 16'h0050);
        do_cmd(3'd5, 23'h000050, 16'h0000, 1'b0, nd);
        check("cs_status", cmd_status, 8'h00);

        // READ after a non-READ op must re-enter array mode.
        push_w(23'h000200, 16'h00FF);
        push_r(23'h000200);
        rd_q.push_back(16'hA5C3);
        do_cmd(3'd0, 23'h000200, 16'h0000, 1'b0, nd);
        check("read3_rdata", cmd_rdata, 16'hA5C3);

        // cmd_start poked while busy must not start a second operation.
        push_r(23'h000300);
        rd_q.push_back(16'h0F0F);
        do_cmd(3'd0, 23'h000300, 16'h0000, 1'b1, nd);
        check("poke_rdata", cmd_rdata, 16'h0F0F);

        // Illegal op: no bus access, error flagged.
        do_cmd(3'd6, 23'h000400, 16'h0000, 1'b0, nd);
        check("illegal_error",   cmd_error,   1);
        check("illegal_timeout", cmd_timeout, 0);

        // Reset while the first PROGRAM write is outstanding.
        push_w(23'h004000, 16'h0040);
        @(negedge clk);
        cmd_start = 1'b1;
        cmd_op    = 3'd1;
        cmd_addr  = 23'h004000;
        cmd_wdata = 16'h7777;
        @(negedge clk);
        cmd_start = 1'b0;
        cyc = 0;
        while (!p1_req && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_req_bound", {39'd0, (cyc < 50)}, 40'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        // The model's late ready lands here and must be ignored.
        cyc = 0;
        repeat (20) begin
            @(negedge clk);
            if (cmd_busy || p1_req) cyc++;
        end
        check("stale_ready_ignored", cyc, 0);
        check("rst_queue_drained", exp_q.size(), 0);

        // Reset cleared array mode: READ issues 00FF again.
        push_w(23'h000100, 16'h00FF);
        push_r(23'h000100);
        rd_q.push_back(16'hC0DE);
        do_cmd(3'd0, 23'h000100, 16'h0000, 1'b0, nd);
        check("read4_rdata", cmd_rdata, 16'hC0DE);
        check("read4_error", cmd_error, 0);

        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
